// File: rtl/odd_even_sort_merge.sv
// Odd-even transposition sorter: captures a lane vector, runs one compare-exchange
// phase per cycle keyed on {~valid, dst}, and presents the sorted vector.
module odd_even_sort_merge #(
    parameter int PORT_NUB       = 16,
    parameter int PORT_NUB_TOTAL = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int FIRST_PHASE    = 0,
    parameter int EARLY_EXIT     = 1,
    localparam int AW            = $clog2(PORT_NUB_TOTAL),
    localparam int WL            = 1 + 2*AW + DATA_WIDTH,
    localparam int PCW           = $clog2(PORT_NUB+1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PORT_NUB*WL-1:0] in_bus,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PORT_NUB*WL-1:0] out_bus,
    output logic                   busy,
    output logic [PCW-1:0]         phase_cnt
);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    localparam logic [PCW-1:0] PN = PCW'(PORT_NUB);

    state_t                          state_q, state_d;
    logic [PORT_NUB-1:0][WL-1:0]     lanes_q, lanes_d, lanes_x;
    logic [PCW-1:0]                  cnt_q, cnt_d, cnt_inc;
    logic                            phase_odd_q, phase_odd_d;
    logic                            swap_prev_q, swap_prev_d;
    logic                            swap_any;
    logic                            last_phase;

    // Invalid lanes get the larger key so they drift to the high lanes.
    function automatic logic [AW:0] laneKey(input logic [WL-1:0] lane);
        return {~lane[WL-1], lane[WL-2 -: AW]};
    endfunction

    // Pairs within one phase are disjoint, so every exchange reads the old lanes.
    always_comb begin
        lanes_x  = lanes_q;
        swap_any = 1'b0;
        for (int i = 0; i < PORT_NUB-1; i++) begin
            if (i[0] == phase_odd_q && laneKey(lanes_q[i]) > laneKey(lanes_q[i+1])) begin
                lanes_x[i]   = lanes_q[i+1];
                lanes_x[i+1] = lanes_q[i];
                swap_any     = 1'b1;
            end
        end
    end

    assign cnt_inc    = cnt_q + PCW'(1);
    assign last_phase = (cnt_inc == PN) ||
                        ((EARLY_EXIT != 0) && (cnt_inc >= PCW'(2)) && !swap_any && !swap_prev_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = SORT;
            SORT:    if (last_phase) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == SORT) || (state_q == DONE);
    end

    always_comb begin
        lanes_d     = lanes_q;
        cnt_d       = cnt_q;
        phase_odd_d = phase_odd_q;
        swap_prev_d = swap_prev_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    lanes_d     = in_bus;
                    cnt_d       = '0;
                    phase_odd_d = (FIRST_PHASE != 0);
                    swap_prev_d = 1'b1;
                end
            end
            SORT: begin
                lanes_d     = lanes_x;
                cnt_d       = cnt_inc;
                phase_odd_d = ~phase_odd_q;
                swap_prev_d = swap_any;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lanes_q     <= '0;
            cnt_q       <= '0;
            phase_odd_q <= (FIRST_PHASE != 0);
            swap_prev_q <= 1'b1;
        end else begin
            lanes_q     <= lanes_d;
            cnt_q       <= cnt_d;
            phase_odd_q <= phase_odd_d;
            swap_prev_q <= swap_prev_d;
        end
    end

    assign out_bus   = lanes_q;
    assign phase_cnt = cnt_q;

endmodule

// File: doc/odd_even_sort_merge.md
ODD_EVEN_SORT_MERGE -- requirements
Module: odd_even_sort_merge

Interface
REQ-001 Parameter PORT_NUB, default 16, lanes per vector; legal range 2..PORT_NUB_TOTAL.
REQ-002 Parameter PORT_NUB_TOTAL, default 16, switch port count; sets address width AW = $clog2(PORT_NUB_TOTAL).
REQ-003 Parameter DATA_WIDTH, default 8, payload bits per lane.
REQ-004 Parameter FIRST_PHASE, default 0, first phase type: 0 = even, 1 = odd.
REQ-005 Parameter EARLY_EXIT, default 1, 1 = enable early termination on a sorted vector.
REQ-006 Lane width WL = 1 + 2*AW + DATA_WIDTH; lane fields MSB..LSB: valid, dst[AW], src[AW], data[DATA_WIDTH]; lane i occupies bus bits [(i+1)*WL-1 : i*WL].
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 in_valid  input  1  input vector offered.
REQ-010 in_ready  output  1  block accepts a vector this cycle.
REQ-011 in_bus  input  PORT_NUB*WL  unsorted lane vector.
REQ-012 out_valid  output  1  sorted vector available.
REQ-013 out_ready  input  1  downstream accepts the sorted vector.
REQ-014 out_bus  output  PORT_NUB*WL  sorted lane vector.
REQ-015 busy  output  1  high in SORT or DONE.
REQ-016 phase_cnt  output  $clog2(PORT_NUB+1)  phases executed on the current vector.

Function
REQ-017 FSM states: IDLE, SORT, DONE; in_ready = (state == IDLE), out_valid = (state == DONE), both decoded from registered state only.
REQ-018 IDLE: on in_valid && in_ready, capture in_bus into lane registers, clear phase_cnt, load phase type = FIRST_PHASE, go to SORT.
REQ-019 SORT: each cycle execute one compare-exchange phase on all pairs simultaneously; even phase pairs (0,1),(2,3)...; odd phase pairs (1,2),(3,4)...; unpaired edge lanes hold their value.
REQ-020 Sort key = {~valid, dst}, unsigned; the pair swaps only if key(lower lane) > key(upper lane); equal keys never swap (stable); invalid lanes migrate to the high lanes.
REQ-021 Swapping moves the full WL-bit lane unchanged; no field is modified.
REQ-022 After each phase: phase_cnt increments by 1, phase type toggles.
REQ-023 SORT -> DONE when phase_cnt reaches PORT_NUB, or, if EARLY_EXIT = 1, when phase_cnt >= 2 and the current and the previous phase both performed zero swaps.
REQ-024 Latency: handshake in cycle k gives out_valid first high in cycle k+PORT_NUB+1 (full run), or k+3 with early exit on already-sorted input.
REQ-025 DONE: out_bus holds stable and out_valid stays high until out_ready; on out_valid && out_ready go to IDLE; in_ready stays low until the IDLE cycle, so no overlap of input and output handshakes.
REQ-026 out_bus is driven from lane registers at all times; its content is don't-care when out_valid is low.
REQ-027 in_valid is ignored outside IDLE; out_ready is ignored outside DONE.

Reset
REQ-028 rst_n low at a clock edge: state = IDLE, lane registers = 0, phase_cnt = 0, phase type = FIRST_PHASE; hence out_bus = 0, out_valid = 0, busy = 0, in_ready = 1 in the following cycle.
REQ-029 Reset in SORT or DONE discards the in-flight vector; no partial output is presented.

Verification
REQ-030 PORT_NUB=4, all lanes valid, dst lanes0..3 = 3,2,1,0 -> out_valid in cycle k+5, dst lanes0..3 = 0,1,2,3, src/data follow their lanes, phase_cnt = 4.
REQ-031 EARLY_EXIT=1, dst = 0,1,2,3 -> out_valid in cycle k+3, phase_cnt = 2, out_bus equals in_bus.
REQ-032 Lane1 invalid with dst=0, others valid with dst = 5,2,7 -> valid lanes sorted 2,5,7 in lanes0..2, invalid lane in lane3.
REQ-033 Two lanes dst=4 with data 0xAA (lane0) and 0xBB (lane2) -> 0xAA still precedes 0xBB on output (stability).
REQ-034 Hold out_ready low 10 cycles in DONE -> out_bus stable, in_ready low; out_ready high -> IDLE and in_ready high in the next cycle.
REQ-035 Assert rst_n low in the 2nd SORT cycle -> next cycle out_valid = 0, out_bus = 0, in_ready = 1, phase_cnt = 0.
